fpcsr_flag_accum: RTL
=====================

// Module: fpcsr_flag_accum
// PURPOSE
//  Writer side of the 32-bit fpcsr the FP units read. Collects the six per-lane 11-bit raise_s exception reports.
//  ORs IEEE flags into the sticky field through a two-stage pipeline and arbitrates against software CSR writes.
//  Raises a held trap request when an enabled flag is raised.
//  Sits beside the FPU cluster in the backend and drives its fpcsr input.
// PARAMETERS
//  LANES      6   number of raise_s report ports (fixed 6 in this build)
//  RST_FPCSR  0   32-bit fpcsr value loaded on reset
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous active-high reset
//  raise_vld   in   6      per-lane report valid
//  raise_s0..5 in   11     per-lane report; [4:0]=NV,DZ,OF,UF,NX; [10:5] reserved, ignored
//  flush       in   1      cancel all not-yet-merged reports (stage1 content and same-cycle inputs)
//  csr_wen     in   1      software write of fpcsr
//  csr_wdata   in   32     software write data
//  fpcsr       out  32     architectural fpcsr; [4:0] sticky flags, [12:8] trap enables, [15:13] rounding mode
//  trap_req    out  1      enabled exception pending
//  trap_cause  out  5      flags that caused trap_req (held while trap_req=1)
//  trap_ack    in   1      consumer accepts trap
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - fpcsr=RST_FPCSR; stage1 valid=0, stage1 flags=0.
//   - trap_req=0; trap_cause=0.
//   - rst wins over every other input in the same cycle.
//  Stage0 (combinational):
//   - f0 = OR over lanes of (raise_vld[i] ? raise_s_i[4:0] : 0).
//   - v0 = |raise_vld.
//  Stage1 register: s1_flags<=f0 and s1_vld<=v0, unless flush=1, in which case both <=0.
//  Stage2 merge (fpcsr update each posedge, priority order):
//   1. csr_wen=1:
//      - fpcsr<=csr_wdata.
//      - If s1_vld and !flush, fpcsr[4:0]<=csr_wdata[4:0]|s1_flags, so older reports are never lost.
//   2. else if s1_vld and !flush: fpcsr[4:0]<=fpcsr[4:0]|s1_flags; other bits unchanged.
//   3. else: hold.
//  Latency:
//   - Report at edge N is visible in fpcsr after edge N+2.
//   - A csr write at edge N is visible after edge N+1.
//  Sticky bits are only cleared by csr_wen or rst; hardware never clears them.
//  Trap FSM, states IDLE/PEND:
//   - IDLE: let hit = s1_flags & fpcsr[12:8] (current enables), with s1_vld && !flush.
//     If hit!=0: trap_cause<=hit, trap_req<=1, go PEND.
//   - PEND: trap_req=1 and trap_cause stable until trap_ack=1. Then trap_req<=0, trap_cause<=0, go IDLE.
//   - New hits while in PEND are ORed into fpcsr only; no second trap is queued.
//   - trap_ack in IDLE is ignored.
//   - flush does not cancel a PEND trap.
//   - Enables are sampled from fpcsr before any same-cycle csr write.
//  Simultaneous trap_ack and new hit in PEND: go IDLE; the hit is dropped for trap purposes (still sticky).
//  Reset mid-PEND: trap_req drops the next cycle; the pending cause is discarded.
//  Back-to-back reports every cycle are merged without stall; the block has no backpressure.
// TESTING
//  - Reset: RST_FPCSR=32'h0000_6000, rst 2 cycles -> fpcsr=32'h6000, trap_req=0.
//  - Lane1 NX (0x001) and lane4 OF (0x004) in the same cycle, enables=0 -> fpcsr[4:0]=5'h05 two edges later, trap_req stays 0.
//  - csr_wen wdata=0 while stage1 holds DZ (0x008) -> fpcsr=32'h8 (write plus preserved flag).
//  - flush in the cycle after a NV report -> fpcsr[4:0] unchanged, no trap.
//  - Enable NV (fpcsr[12:8]=5'h10), report NV -> trap_req=1, trap_cause=5'h10.
//    Hold 3 cycles, then trap_ack -> trap_req=0 the next cycle.
//  - trap_ack and a new enabled hit in the same cycle in PEND -> IDLE, trap_req=0, sticky bit set.
//    rst asserted mid-PEND -> trap_req=0.

Source files
------------

// File: rtl/fpcsr_flag_accum.sv
// fpcsr writer: merges per-lane IEEE exception reports into the sticky flags through a
// two-stage pipeline, arbitrates against software CSR writes and raises a held trap request.
module fpcsr_flag_accum #(
    parameter int          LANES     = 6,
    parameter logic [31:0] RST_FPCSR = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] raise_vld,
    input  logic [10:0]      raise_s0,
    input  logic [10:0]      raise_s1,
    input  logic [10:0]      raise_s2,
    input  logic [10:0]      raise_s3,
    input  logic [10:0]      raise_s4,
    input  logic [10:0]      raise_s5,
    input  logic             flush,
    input  logic             csr_wen,
    input  logic [31:0]      csr_wdata,
    output logic [31:0]      fpcsr,
    output logic             trap_req,
    output logic [4:0]       trap_cause,
    input  logic             trap_ack
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t      state_q, state_d;
    logic [4:0]  trap_cause_q, trap_cause_d;
    logic [31:0] fpcsr_q, fpcsr_d;
    logic [4:0]  s1_flags_q, s1_flags_d;
    logic        s1_vld_q, s1_vld_d;

    logic [4:0]  lane_flags [6];
    logic [4:0]  f0;
    logic        v0;
    logic        merge_en;
    logic [4:0]  hit;
    logic        unused_reserved;

    assign lane_flags[0] = raise_s0[4:0];
    assign lane_flags[1] = raise_s1[4:0];
    assign lane_flags[2] = raise_s2[4:0];
    assign lane_flags[3] = raise_s3[4:0];
    assign lane_flags[4] = raise_s4[4:0];
    assign lane_flags[5] = raise_s5[4:0];

    assign unused_reserved = ^{raise_s0[10:5], raise_s1[10:5], raise_s2[10:5],
                               raise_s3[10:5], raise_s4[10:5], raise_s5[10:5]};

    // Stage0: OR together the flags of every valid lane
    always_comb begin
        f0 = 5'h0;
        for (int i = 0; i < LANES && i < 6; i++) begin
            if (raise_vld[i]) begin
                f0 = f0 | lane_flags[i];
            end
        end
        v0 = |raise_vld;
    end

    // Stage1: registered report, killed by flush
    always_comb begin
        s1_flags_d = f0;
        s1_vld_d   = v0;
        if (flush) begin
            s1_flags_d = 5'h0;
            s1_vld_d   = 1'b0;
        end
    end

    assign merge_en = s1_vld_q && !flush;

    // Stage2: software write wins, but a report already in stage1 is still ORed in
    always_comb begin
        fpcsr_d = fpcsr_q;
        if (csr_wen) begin
            fpcsr_d = csr_wdata;
            if (merge_en) begin
                fpcsr_d[4:0] = csr_wdata[4:0] | s1_flags_q;
            end
        end else if (merge_en) begin
            fpcsr_d[4:0] = fpcsr_q[4:0] | s1_flags_q;
        end
    end

    // Enables come from the current fpcsr, not from a same-cycle write
    assign hit = merge_en ? (s1_flags_q & fpcsr_q[12:8]) : 5'h0;

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        case (state_q)
            IDLE: begin
                if (hit != 5'h0) begin
                    state_d      = PEND;
                    trap_cause_d = hit;
                end
            end
            PEND: begin
                if (trap_ack) begin
                    state_d      = IDLE;
                    trap_cause_d = 5'h0;
                end
            end
            default: begin
                state_d      = IDLE;
                trap_cause_d = 5'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpcsr_q      <= RST_FPCSR;
            s1_flags_q   <= 5'h0;
            s1_vld_q     <= 1'b0;
            state_q      <= IDLE;
            trap_cause_q <= 5'h0;
        end else begin
            fpcsr_q      <= fpcsr_d;
            s1_flags_q   <= s1_flags_d;
            s1_vld_q     <= s1_vld_d;
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign fpcsr      = fpcsr_q;
    assign trap_req   = (state_q == PEND);
    assign trap_cause = trap_cause_q;

endmodule
